// File: rtl/mips_data_mem.sv
// Data-memory slave for the 5-stage MIPS core: word-addressed RAM plus a
// memory-mapped console transmitter with a byte FIFO. Load data is registered.
module mips_data_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          TX_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        rd_wr,
  output logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
  localparam logic [29:0] MMIO_W = MMIO_BASE[31:2];

  logic [29:0]   word;
  logic [29:0]   word_off;
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          tx_hit;
  logic          st_hit;
  logic          unused_bits;

  logic [31:0]   ram [DEPTH_WORDS];

  logic [7:0]    fifo [TX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          accept;
  logic          ovf_clr;
  logic [31:0]   status;

  // Byte offset bits never take part in the decode.
  assign unused_bits = ^addr[1:0];

  assign word     = addr[31:2];
  assign word_off = word - BASE_W;
  assign ram_idx  = word_off[AW-1:0];
  assign ram_hit  = (word >= BASE_W) && (word_off < 30'(DEPTH_WORDS));
  assign tx_hit   = (word == MMIO_W);
  assign st_hit   = (word == MMIO_W + 30'd1);

  assign full     = (count == CW'(TX_DEPTH));
  assign empty    = (count == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo[rd_ptr];

  assign push     = !rd_wr && tx_hit;
  assign pop      = tx_valid && tx_ready;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign accept   = push && (!full || pop);
  assign ovf_clr  = !rd_wr && st_hit && wr_data[16];
  assign status   = {15'b0, ovf, 6'b0, empty, full, 3'b0, 5'(count)};

  always_ff @(posedge clk) begin
    if (!reset && !rd_wr && ram_hit) begin
      ram[ram_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      err <= !(ram_hit || tx_hit || st_hit);
      if (!rd_wr) begin
        rd_data <= '0;
      end else if (ram_hit) begin
        rd_data <= ram[ram_idx];
      end else if (st_hit) begin
        rd_data <= status;
      end else begin
        rd_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      fifo[wr_ptr] <= wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (accept && !pop) begin
        count <= count + CW'(1);
      end else if (!accept && pop) begin
        count <= count - CW'(1);
      end
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_data_mem.sv
// Scoreboard bench for mips_data_mem: stimulus queues expected load data and
// console bytes, a negedge monitor pops and compares them.
module tb_mips_data_mem;

  localparam logic [31:0] TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] STATUS = 32'hFFFF_0004;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_wr = 1'b1;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        err;

  rd_exp_t     exp_q[$];
  logic [7:0]  tx_q[$];
  logic        chk_rd = 1'b0;
  logic        rd_due = 1'b0;
  int          checks = 0;
  int          errors = 0;

  mips_data_mem dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_wr    (rd_wr),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the posedge and hold for one full cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w_n,
                               input bit check, input logic [31:0] ed, input logic ee);
    rd_exp_t e;
    addr    = a;
    wr_data = d;
    rd_wr   = w_n;
    chk_rd  = check;
    if (check) begin
      e.data = ed;
      e.err  = ee;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic ee);
    applyStimulus(a, d, 1'b0, 1'b1, 32'h0, ee);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic ee);
    applyStimulus(a, 32'h0, 1'b1, 1'b1, ed, ee);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_out);
    if (expect_out) tx_q.push_back(b);
    do_write(TXDATA, {24'h0, b}, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  // Load data of cycle t is compared in the middle of cycle t+1; a console
  // handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_due) begin
      if (exp_q.size() == 0) begin
        checkOutput("rd_queue_empty", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rd_data", rd_data, e.data);
        checkOutput("err", {31'b0, err}, {31'b0, e.err});
      end
    end
    rd_due = chk_rd;
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checkOutput("tx_unexpected_byte", {24'h0, tx_data}, 32'h0);
      end else begin
        checkOutput("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("reset_rd_data", rd_data, 32'h0);
    checkOutput("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("reset_err", {31'b0, err}, 32'h0);

    // RAM write/read, byte offset ignored, region boundaries.
    do_write(32'h0000_0000, 32'h0000_0000, 1'b0);
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_read (32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_read (32'h0000_0013, 32'hDEAD_BEEF, 1'b0);
    do_write(32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);
    do_read (32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);
    do_read (32'h0000_1000, 32'h0, 1'b1);
    do_read (32'h0000_0000, 32'h0, 1'b0);

    // Console ordering.
    tx_ready = 1'b0;
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    do_read(STATUS, 32'h0000_0003, 1'b0);
    tx_ready = 1'b1;
    do_read(TXDATA, 32'h0, 1'b0);
    idle(2);
    checkOutput("drain3_tx_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("drain3_left", 32'(tx_q.size()), 32'h0);

    // Overflow and sticky flag clear.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b1);
    push_byte(8'h99, 1'b0);
    do_read (STATUS, 32'h0001_0108, 1'b0);
    do_write(STATUS, 32'h0001_0000, 1'b0);
    do_read (STATUS, 32'h0000_0108, 1'b0);

    // Push into a full FIFO while the head leaves.
    tx_ready = 1'b1;
    push_byte(8'h55, 1'b1);
    tx_ready = 1'b0;
    do_read(STATUS, 32'h0000_0108, 1'b0);
    tx_ready = 1'b1;
    idle(8);
    checkOutput("drain8_tx_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("drain8_left", 32'(tx_q.size()), 32'h0);
    tx_ready = 1'b0;

    // Unmapped accesses, including neighbours of the console registers.
    do_read (32'h8000_0000, 32'h0, 1'b1);
    do_read (32'h0000_0000, 32'h0, 1'b0);
    do_write(32'h8000_0010, 32'h1234_5678, 1'b1);
    do_read (32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_read (32'hFFFE_FFFC, 32'h0, 1'b1);
    do_write(32'hFFFF_0008, 32'h0000_00AA, 1'b1);
    do_read (STATUS, 32'h0000_0200, 1'b0);

    // Reset in the middle of a queued burst, with a RAM write in the reset cycle.
    do_write(32'h0000_0020, 32'h0000_1111, 1'b0);
    for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i), 1'b0);
    do_read(STATUS, 32'h0000_0005, 1'b0);
    reset = 1'b1;
    do_write(32'h0000_0020, 32'h0000_0BAD, 1'b0);
    reset = 1'b0;
    checkOutput("post_reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b1;
    do_read(STATUS, 32'h0000_0200, 1'b0);
    do_read(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h0000_0020, 32'h0000_1111, 1'b0);
    idle(3);

    checkOutput("rd_left", 32'(exp_q.size()), 32'h0);
    checkOutput("tx_left", 32'(tx_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
